// File: rtl/alu_trace_pkg.sv
// Shared types and record layout for the ALU trace recorder.
// A record is {aluop, a, b, result}, matching the ALU test-vector format.
package alu_trace_pkg;
  localparam int REC_W = 100;
  localparam int OP_HI = 99;
  localparam int A_HI  = 95;
  localparam int B_HI  = 63;
  localparam int R_HI  = 31;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
endpackage

// File: rtl/alu_trace_recorder_if.sv
// Snoop, control and pop-side signals of the trace recorder.
interface alu_trace_recorder_if
  import alu_trace_pkg::*;
#(
  parameter int CNT_W = 7
);
  logic             start;
  logic             stop;
  logic             valid_in;
  logic [3:0]       aluop;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [31:0]      result;
  logic             rd_req;
  logic [REC_W-1:0] rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             capturing;

  modport master (
    output start, stop, valid_in, aluop, a, b, result, rd_req,
    input  rd_data, rd_valid, count, empty, full, overflow, capturing
  );

  modport slave (
    input  start, stop, valid_in, aluop, a, b, result, rd_req,
    output rd_data, rd_valid, count, empty, full, overflow, capturing
  );
endinterface

// File: rtl/alu_trace_recorder_trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module trace_ram #(
  parameter int DEPTH = 100,
  parameter int REC_W = 100,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [REC_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [REC_W-1:0] rdata
);
  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value between pops; array itself is never reset.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/alu_trace_recorder.sv
// Captures one {aluop, a, b, result} record per ALU op into a circular
// buffer while in CAPTURE; records are drained through a one-cycle pop port.
module alu_trace_recorder
  import alu_trace_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_trace_recorder_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state, state_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             rd_valid;
  logic             push, pop;
  logic             at_full_m1;
  logic [REC_W-1:0] wdata;

  // start takes priority over any push or pop in the same cycle.
  always_comb begin
    push       = !bus.start && (state == CAPTURE) && bus.valid_in &&
                 (count < CNT_W'(DEPTH));
    pop        = !bus.start && bus.rd_req && (count != '0);
    at_full_m1 = (count == CNT_W'(DEPTH - 1));
  end

  always_comb begin
    wdata                   = '0;
    wdata[OP_HI -: 4]       = bus.aluop;
    wdata[A_HI  -: 32]      = bus.a;
    wdata[B_HI  -: 32]      = bus.b;
    wdata[R_HI  -: 32]      = bus.result;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.start)
      state_nxt = CAPTURE;
    else if (bus.stop && (state != IDLE))
      state_nxt = IDLE;
    else if ((state == CAPTURE) && push && !pop && at_full_m1)
      state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (bus.start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        // Only DONE counts as dropping; IDLE simply isn't listening.
        if ((state == DONE) && bus.valid_in) overflow <= 1'b1;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid  = rd_valid;
  assign bus.count     = count;
  assign bus.empty     = (count == '0);
  assign bus.full      = (count == CNT_W'(DEPTH));
  assign bus.overflow  = overflow;
  assign bus.capturing = (state == CAPTURE);
endmodule

// File: tb/tb_alu_trace_recorder.sv
// Bench for alu_trace_recorder: queue-based reference model checked every
// cycle, a vector table, directed corner sequences and random traffic.
module tb_alu_trace_recorder;
  localparam int DEPTH = 100;
  localparam int CNT_W = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_trace_recorder_if #(.CNT_W(CNT_W)) bus ();

  alu_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: a queue of records plus a mode number.
  // mode 0 = not listening, 1 = capturing, 2 = buffer filled (drops counted).
  logic [99:0] q[$];
  int          mode;
  bit          m_ovf;
  logic [99:0] m_rd;
  bit          m_rv;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [99:0] exp;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input bit rst, st, sp, v, rq, input logic [99:0] rec);
    bit push_ok, pop_ok;
    if (rst) begin
      mode = 0; q.delete(); m_ovf = 0; m_rd = '0; m_rv = 0;
      return;
    end
    if (st) begin
      mode = 1; q.delete(); m_ovf = 0; m_rv = 0;
      return;
    end
    push_ok = (mode == 1) && v && (q.size() < DEPTH);
    pop_ok  = rq && (q.size() > 0);
    if (mode == 2 && v) m_ovf = 1;
    m_rv = pop_ok;
    if (pop_ok)  m_rd = q.pop_front();
    if (push_ok) q.push_back(rec);
    if (sp && mode != 0) mode = 0;
    else if (mode == 1 && push_ok && q.size() == DEPTH) mode = 2;
  endtask

  task automatic step(input bit rst, st, sp, v, rq, input logic [99:0] rec);
    reset        = rst;
    bus.start    = st;
    bus.stop     = sp;
    bus.valid_in = v;
    bus.rd_req   = rq;
    {bus.aluop, bus.a, bus.b, bus.result} = rec;
    @(posedge clk);
    model(rst, st, sp, v, rq, rec);
    #1;
    chk("count",     bus.count,     q.size());
    chk("empty",     bus.empty,     q.size() == 0);
    chk("full",      bus.full,      q.size() == DEPTH);
    chk("overflow",  bus.overflow,  m_ovf);
    chk("capturing", bus.capturing, mode == 1);
    chk("rd_valid",  bus.rd_valid,  m_rv);
    chk("rd_data",   bus.rd_data,   m_rd);
  endtask

  function automatic logic [99:0] mk(input logic [3:0] op, input logic [31:0] a, b, r);
    return {op, a, b, r};
  endfunction

  task automatic idle_cyc();   step(0, 0, 0, 0, 0, '0); endtask
  task automatic do_start();   step(0, 1, 0, 0, 0, '0); endtask
  task automatic push(input logic [99:0] rec); step(0, 0, 0, 1, 0, rec); endtask
  task automatic pop();        step(0, 0, 0, 0, 1, '0); endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0010, 32'h5,  32'h7,  32'hC,        100'h2_00000005_00000007_0000000C};
    tbl[1] = '{4'b0110, 32'h5,  32'h7,  32'hFFFFFFFE, 100'h6_00000005_00000007_FFFFFFFE};
    tbl[2] = '{4'b0000, 32'hF0, 32'h0F, 32'h0,        100'h0_000000F0_0000000F_00000000};

    // Reset state
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_rd_data", bus.rd_data, 100'h0);
    idle_cyc();

    // Vector table: push three, pop three
    do_start();
    for (int i = 0; i < 3; i++) push(mk(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r));
    chk("vec_count", bus.count, 7'd3);
    for (int i = 0; i < 3; i++) begin
      pop();
      chk("vec_rd_data", bus.rd_data, tbl[i].exp);
    end
    chk("vec_empty", bus.empty, 1'b1);

    // Fill to DEPTH, then one dropped record, then drain in order
    do_start();
    for (int i = 0; i < DEPTH; i++) push(mk(4'h2, 32'h1, 32'h2, 32'(i)));
    chk("fill_full", bus.full, 1'b1);
    chk("fill_done_not_capturing", bus.capturing, 1'b0);
    push(mk(4'h2, 32'h1, 32'h2, 32'hDEAD));
    chk("fill_overflow", bus.overflow, 1'b1);
    chk("fill_count", bus.count, 7'd100);
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      chk("fill_order", bus.rd_data[31:0], 32'(i));
    end

    // Pointer wrap: 60 in, 60 out, 60 in
    do_start();
    for (int i = 0; i < 60; i++) push(mk(4'h1, 32'h3, 32'h4, 32'(i)));
    for (int i = 0; i < 60; i++) pop();
    for (int i = 0; i < 60; i++) push(mk(4'h1, 32'h3, 32'h4, 32'(1000 + i)));
    chk("wrap_count", bus.count, 7'd60);
    for (int i = 0; i < 60; i++) begin
      pop();
      chk("wrap_order", bus.rd_data[31:0], 32'(1000 + i));
    end

    // Push and pop together at DEPTH-1; then pop on empty
    do_start();
    for (int i = 0; i < DEPTH - 1; i++) push(mk(4'h7, 32'(i), 32'h0, 32'(i)));
    step(0, 0, 0, 1, 1, mk(4'h7, 32'h99, 32'h0, 32'h99));
    chk("pp_count", bus.count, 7'd99);
    chk("pp_capturing", bus.capturing, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    pop();
    chk("empty_pop_rd_valid", bus.rd_valid, 1'b0);

    // start coincident with valid_in, then valid_in while idle
    step(0, 1, 0, 1, 0, mk(4'h2, 32'h1, 32'h1, 32'h2));
    chk("start_vin_count", bus.count, 7'd0);
    push(mk(4'h2, 32'h1, 32'h1, 32'h2));
    push(mk(4'h2, 32'h2, 32'h2, 32'h4));
    step(0, 0, 1, 0, 0, '0);
    push(mk(4'h2, 32'h3, 32'h3, 32'h6));
    chk("idle_vin_count", bus.count, 7'd2);
    chk("idle_vin_ovf", bus.overflow, 1'b0);

    // Reset mid-capture at count 40
    do_start();
    for (int i = 0; i < 40; i++) push(mk(4'h3, 32'(i), 32'h1, 32'(i)));
    step(1, 0, 0, 1, 1, mk(4'h3, 32'h0, 32'h0, 32'h0));
    chk("midrst_count", bus.count, 7'd0);
    chk("midrst_empty", bus.empty, 1'b1);
    chk("midrst_capturing", bus.capturing, 1'b0);
    chk("midrst_ovf", bus.overflow, 1'b0);

    // Random traffic in phases with different read pressure
    for (int ph = 0; ph < 6; ph++) begin
      int rq_pct = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 50 : 80;
      for (int i = 0; i < 500; i++) begin
        bit rst = ($urandom_range(0, 399) == 0);
        bit st  = ($urandom_range(0, 149) == 0);
        bit sp  = ($urandom_range(0, 199) == 0);
        bit v   = ($urandom_range(0, 99) < 70);
        bit rq  = ($urandom_range(0, 99) < rq_pct);
        step(rst, st, sp, v, rq, {4'($urandom), $urandom, $urandom, $urandom});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/alu_trace_recorder.md
# alu_trace_recorder

Synthesizable capture unit that snoops the ALU ports in the MIPS datapath and stores one 100-bit record per executed ALU operation, packed as {aluop, a, b, result}. The record layout is the same as the ALU test-vector format, so a captured trace, dumped in hex, is a ready-made vector file for the ALU bench. It sits beside the ALU and is read out afterwards through a pop interface.

## Interface
- DEPTH, 100: number of records held; any value from 2 to 127.
- CNT_W, 7: width of count, equal to $clog2(DEPTH+1).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse: clear the buffer and begin capturing.
- stop  in  1  one-cycle pulse: end capturing.
- valid_in  in  1  an ALU operation completes this cycle.
- aluop  in  4  ALU operation code.
- a  in  32  ALU operand A.
- b  in  32  ALU operand B.
- result  in  32  ALU result.
- rd_req  in  1  pop the oldest record.
- rd_data  out  100  popped record {aluop[99:96], a[95:64], b[63:32], result[31:0]}.
- rd_valid  out  1  rd_data holds a newly popped record.
- count  out  CNT_W  records currently stored.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: at least one record was dropped.
- capturing  out  1  the state machine is in CAPTURE.

## Operation
- States:
  - IDLE (reset state).
  - CAPTURE.
  - DONE.
- State transitions, in priority order:
  - reset goes to IDLE from any state.
  - start goes to CAPTURE from any state. In the same cycle it zeroes wr_ptr, rd_ptr and count and clears overflow.
  - stop goes from CAPTURE or DONE to IDLE. Stored data is kept.
  - In CAPTURE, a push that makes count reach DEPTH goes to DONE.
- Push: happens when valid_in is high in CAPTURE and count < DEPTH.
  - Writes {aluop, a, b, result} to mem[wr_ptr].
  - wr_ptr then increments.
- Dropped records:
  - valid_in in DONE sets overflow.
  - valid_in in IDLE is ignored and does not set overflow.
- Pop: happens when rd_req is high and count > 0, in any state.
  - rd_data <= mem[rd_ptr], and rd_ptr increments.
  - rd_req when empty is ignored: rd_valid stays 0 and rd_data holds its value.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. DEPTH need not be a power of two.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when a push and a pop happen in the same cycle.
- Simultaneous events:
  - start and valid_in in the same cycle: the record is not captured, because start wins.
  - start and rd_req in the same cycle: the pop is ignored.
  - Push and pop at count == DEPTH-1: count stays DEPTH-1 and the state stays CAPTURE.
  - Pop in DONE: frees one slot, but the state stays DONE. Only start leaves DONE for CAPTURE.
- The zero flag is not recorded; consumers derive it as result == 0.

## Timing
- Reset values:
  - state = IDLE; wr_ptr, rd_ptr and count = 0.
  - rd_data = 0, rd_valid = 0.
  - empty = 1, full = 0, overflow = 0, capturing = 0.
- Push latency:
  - The record is written at the clk edge where valid_in is sampled high.
  - count, empty and full reflect the push after that same edge.
- Pop latency: one cycle. rd_valid is high exactly one cycle after an accepted rd_req. Back-to-back rd_req gives one record per cycle.
- Read-after-write: the earliest a record can be popped is the cycle after its push edge. Same-address read and write in one cycle cannot occur, since the slot must be non-empty to be read.
- overflow is set on the edge after the dropped valid_in.
- Reset asserted mid-capture or mid-readout:
  - All outputs return to their reset values on the next edge.
  - The memory contents are don't-care.

## Structure
- Package alu_trace_pkg holds:
  - REC_W = 100.
  - Field bounds: OP_HI = 99, A_HI = 95, B_HI = 63, R_HI = 31.
  - State enum {IDLE, CAPTURE, DONE}.
- Sub-module trace_ram:
  - Simple dual-port: one write port, one registered synchronous read port.
  - Parameters: DEPTH and REC_W.
- The top level holds the FSM, pointers, count and flags.

## Test plan
- Reset, then start, then push 3 records: (0010, 5, 7, C), (0110, 5, 7, FFFFFFFE), (0000, F0, 0F, 0). Expect count = 3. Three rd_req give rd_data = 2_00000005_00000007_0000000C, then 6_00000005_00000007_FFFFFFFE, then 0_000000F0_0000000F_00000000, then empty = 1.
- Push 100 records with result = index. Expect full = 1 and the state in DONE. Push 1 more: expect overflow = 1 and count = 100. Pop all: expect results 0..99 in order.
- Pop after a wrap: push 60, pop 60, push 60. Expect count = 60 and the pointers wrapped. Pops return the second batch in order.
- At count = 99, push and pop in the same cycle. Expect count to stay 99 and capturing = 1. rd_req on an empty buffer: expect rd_valid = 0.
- start coincident with valid_in: expect count = 0. valid_in while IDLE (after stop): expect count unchanged and overflow = 0.
- Assert reset during capture at count = 40. Expect count = 0, empty = 1, state IDLE, overflow = 0 on the next edge.
